// File: rtl/multiplier.sv
// Sequential signed multiplier, radix-2 Booth. Operands arrive serially on
// data_in (multiplicand, then multiplier); the 2*SIZE-bit product comes out with a done pulse.
module multiplier #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SIZE-1:0]     data_in,
    output logic [2*SIZE-1:0]   data_out,
    output logic                done
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        RUN,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE:0]       m_q, m_d;
    logic [SIZE:0]       a_q, a_d;
    logic [SIZE-1:0]     q_q, q_d;
    logic                q1_q, q1_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*SIZE-1:0]   data_out_q, data_out_d;
    logic                done_q, done_d;
    logic [SIZE:0]       sum;

    // One extra bit in A and M keeps -M representable for the most negative multiplicand.
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        a_d        = a_q;
        q_d        = q_q;
        q1_d       = q1_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_M;
                end
            end
            LOAD_M: begin
                m_d     = {data_in[SIZE-1], data_in};
                state_d = LOAD_Q;
            end
            LOAD_Q: begin
                q_d     = data_in;
                a_d     = '0;
                q1_d    = 1'b0;
                count_d = CW'(SIZE);
                state_d = RUN;
            end
            RUN: begin
                a_d     = {sum[SIZE], sum[SIZE:1]};
                q_d     = {sum[0], q_q[SIZE-1:1]};
                q1_d    = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                data_out_d = {a_q[SIZE-1:0], q_q};
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            m_q        <= '0;
            a_q        <= '0;
            q_q        <= '0;
            q1_q       <= 1'b0;
            count_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            a_q        <= a_d;
            q_q        <= q_d;
            q1_q       <= q1_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the Booth multiplier: expected product and start cycle
// are queued when an operation starts and checked when done pulses.
module tb_multiplier;

    localparam int SIZE = 8;
    localparam int LAT  = SIZE + 3;

    logic                clk;
    logic                reset;
    logic                start;
    logic [SIZE-1:0]     data_in;
    logic [2*SIZE-1:0]   data_out;
    logic                done;

    typedef struct {
        logic [2*SIZE-1:0] prod;
        int                start_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    multiplier #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                exp_t e;
                chk_eq("done_single_cycle", {31'd0, prev_done}, 32'd0);
                chk_eq("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_eq("product", {16'd0, data_out}, {16'd0, e.prod});
                    chk_eq("latency", cyc - e.start_cyc, LAT);
                    $display("txn product=%04h expected=%04h latency=%0d", data_out, e.prod,
                             cyc - e.start_cyc);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Call with the bench just after a posedge or at a negedge; returns at
    // the negedge where done is seen (or an abort point).
    task automatic do_mul(input int a, input int b, input int glitch, input bit abort);
        exp_t e;
        int   n;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!abort) begin
            e.prod      = 16'(a * b);
            e.start_cyc = cyc;
            sb.push_back(e);
        end
        start   = 1'b0;
        data_in = 8'(a);
        @(posedge clk);
        #1;
        data_in = 8'(b);
        @(posedge clk);
        #1;
        data_in = 8'($urandom);
        if (abort) begin
            repeat (3) @(negedge clk);
            #2;
            reset = 1'b0;
            #1;
            chk_eq("abort_done", {31'd0, done}, 32'd0);
            chk_eq("abort_data_out", {16'd0, data_out}, 32'd0);
            $display("txn reset during RUN done=%0b data_out=%04h", done, data_out);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            return;
        end
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = (glitch > 0 && n == glitch);
            if (done) break;
        end
        start = 1'b0;
        if (n > 40) chk_eq("timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #3;
        chk_eq("reset_done", {31'd0, done}, 32'd0);
        chk_eq("reset_data_out", {16'd0, data_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        do_mul(14, 5, 0, 1'b0);
        do_mul(51, -3, 0, 1'b0);
        do_mul(4, 10, 0, 1'b0);
        // back-to-back chain: each start is sampled on the edge after done
        do_mul(11, -6, 0, 1'b0);
        do_mul(7, -19, 0, 1'b0);
        do_mul(-128, -128, 0, 1'b0);
        do_mul(-128, 127, 0, 1'b0);
        do_mul(0, -1, 0, 1'b0);
        do_mul(-1, -1, 0, 1'b0);
        do_mul(127, 127, 0, 1'b0);
        do_mul(-128, 1, 0, 1'b0);

        do_mul(100, 100, 0, 1'b1);
        do_mul(3, 3, 0, 1'b0);

        do_mul(-37, 23, 3, 1'b0);
        do_mul(9, -9, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_mul($signed(8'($urandom)), $signed(8'($urandom)), 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
